ifetch_queue: RTL and testbench

Instruction fetch front end for the RISC-V core. It issues word-aligned read requests to a pipelined instruction memory, buffers returned words in a small in-order queue, and presents PC/instruction pairs to the decode stage through a valid/ready handshake. A redirect input from the execute stage (branch, jal, jalr) flushes the queue and restarts fetch at the target address. Responses still in flight at the time of a redirect are discarded.

---
 rtl/ifetch_queue_pkg.sv | 20 ++
 rtl/ifetch_queue_fifo.sv | 97 +++++++++
 rtl/ifetch_queue.sv | 179 +++++++++++++++++
 tb/tb_ifetch_queue.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_queue_pkg.sv
// ifetch_queue_pkg: shared configuration for the instruction fetch queue.
//   IFQ_DEPTH      default queue depth / outstanding request limit
//   IFQ_NOP        canonical RISC-V NOP (addi x0, x0, 0) for bench use
//   ifq_entry_t    {pc, ir} pair stored in the instruction queue
//   ifq_word_align clears the byte-offset bits of an address
package ifetch_queue_pkg;

  localparam int          IFQ_DEPTH = 4;
  localparam logic [31:0] IFQ_NOP   = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } ifq_entry_t;

  function automatic logic [31:0] ifq_word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_queue_fifo.sv
// ifq_fifo: parameterised synchronous FIFO with push/pop/flush.
//   CLK, RST     clock, asynchronous active-high reset
//   push/push_data  write request and data
//   pop          remove the head entry (ignored when empty)
//   flush        empty the FIFO; wins over push/pop in the same cycle
//   head_data    current head entry (register output)
//   full/empty/count  occupancy status
// A push while full is accepted when a pop happens in the same cycle.
module ifq_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [WIDTH-1:0]       head_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int            PW       = $clog2(DEPTH);
  localparam int            CW       = PW + 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_q == CNT_FULL);
  assign empty     = (count_q == {CW{1'b0}});
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  // Qualify push/pop against occupancy.
  always_comb begin
    do_pop_s  = pop && !empty;
    do_push_s = push && (!full || do_pop_s);
  end

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction fetch front end.
// Issues word-aligned requests to a pipelined instruction memory, queues the
// returned words in order and hands {PC, IR} pairs to decode via IF_VALID /
// IF_READY. REDIR flushes the queue, restarts fetch at REDIR_PC and marks every
// response still in flight for discard.
//   CLK, RST                          clock, asynchronous active-high reset
//   IM_REQ, IM_ADDR, IM_GNT           request channel (word address)
//   IM_RVALID, IM_RDATA               in-order response channel
//   IF_VALID, IF_PC, IF_IR, IF_READY  decode handshake
//   REDIR, REDIR_PC                   redirect from execute
// Build option: IFQ_BYPASS_EN -- when the queue is empty and nothing is being
// discarded, a response is presented to decode in the same cycle. Without it,
// every IF_* output comes from the queue head registers.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int          DEPTH    = IFQ_DEPTH,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        IM_REQ,
  output logic [29:0] IM_ADDR,
  input  logic        IM_GNT,
  input  logic        IM_RVALID,
  input  logic [31:0] IM_RDATA,
  output logic        IF_VALID,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_IR,
  input  logic        IF_READY,
  input  logic        REDIR,
  input  logic [31:0] REDIR_PC
);

  localparam int             CW         = $clog2(DEPTH) + 1;
  localparam int             SW         = CW + 1;
  localparam logic [CW-1:0]  CNT_ONE    = CW'(1);
  localparam logic [CW-1:0]  CNT_ZERO   = CW'(0);
  localparam logic [SW-1:0]  CREDIT_MAX = SW'(DEPTH);

  logic [31:0]   fpc_q, fpc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_q, drop_d;

  logic          grant_s;
  logic          resp_s;
  logic          drop_hit_s;
  logic          dq_push_s;
  logic          dq_pop_s;
  logic [SW-1:0] credit_sum_s;

  logic [31:0]   tag_head_s;
  logic          tag_full_s;
  logic          tag_empty_s;
  logic [CW-1:0] tag_count_s;

  ifq_entry_t    dq_head_s;
  ifq_entry_t    dq_push_data_s;
  logic          dq_full_s;
  logic          dq_empty_s;
  logic [CW-1:0] dq_count_s;

`ifdef IFQ_BYPASS_EN
  logic          byp_s;
`endif

  logic          unused_ok_s;
  assign unused_ok_s = ^{tag_full_s, tag_empty_s, tag_count_s, dq_full_s, REDIR_PC[1:0]};

  // Per-request PC tags, written on grant and consumed by every response
  // (including discarded ones) so tags stay aligned with the memory pipeline.
  ifq_fifo #(
    .WIDTH(32),
    .DEPTH(DEPTH)
  ) u_tag_fifo (
    .CLK      (CLK),
    .RST      (RST),
    .push     (grant_s),
    .push_data(fpc_q),
    .pop      (resp_s),
    .flush    (1'b0),
    .head_data(tag_head_s),
    .full     (tag_full_s),
    .empty    (tag_empty_s),
    .count    (tag_count_s)
  );

  // Instruction queue of {pc, ir} pairs; a redirect empties it.
  ifq_fifo #(
    .WIDTH(64),
    .DEPTH(DEPTH)
  ) u_data_fifo (
    .CLK      (CLK),
    .RST      (RST),
    .push     (dq_push_s),
    .push_data(dq_push_data_s),
    .pop      (dq_pop_s),
    .flush    (REDIR),
    .head_data(dq_head_s),
    .full     (dq_full_s),
    .empty    (dq_empty_s),
    .count    (dq_count_s)
  );

  // A request is only issued when a queue slot is reserved for its response.
  assign credit_sum_s = {1'b0, dq_count_s} + {1'b0, inflight_q};
  assign IM_REQ       = !RST && !REDIR && (credit_sum_s < CREDIT_MAX);
  assign IM_ADDR      = fpc_q[31:2];

  // Handshake decode for the memory and queue channels.
  always_comb begin
    grant_s        = IM_REQ && IM_GNT;
    // A response with nothing outstanding is a protocol error and is ignored.
    resp_s         = IM_RVALID && (inflight_q != CNT_ZERO);
    drop_hit_s     = resp_s && (drop_q != CNT_ZERO);
    dq_push_data_s = '{pc: tag_head_s, ir: IM_RDATA};
    dq_pop_s       = !dq_empty_s && IF_READY;
`ifdef IFQ_BYPASS_EN
    byp_s          = (dq_count_s == CNT_ZERO) && (drop_q == CNT_ZERO) && !REDIR && resp_s;
    // A bypassed word taken by decode this cycle never enters the queue.
    dq_push_s      = resp_s && !drop_hit_s && !REDIR && !(byp_s && IF_READY);
`else
    dq_push_s      = resp_s && !drop_hit_s && !REDIR;
`endif
  end

`ifdef IFQ_BYPASS_EN
  assign IF_VALID = byp_s || !dq_empty_s;
  assign IF_PC    = byp_s ? tag_head_s : dq_head_s.pc;
  assign IF_IR    = byp_s ? IM_RDATA   : dq_head_s.ir;
`else
  assign IF_VALID = !dq_empty_s;
  assign IF_PC    = dq_head_s.pc;
  assign IF_IR    = dq_head_s.ir;
`endif

  // Next fetch PC: redirect wins, otherwise advance by one word per grant.
  always_comb begin
    if (REDIR) begin
      fpc_d = ifq_word_align(REDIR_PC);
    end else if (grant_s) begin
      fpc_d = fpc_q + 32'd4;
    end else begin
      fpc_d = fpc_q;
    end
  end

  // Outstanding-request and discard counters.
  always_comb begin
    case ({grant_s, resp_s})
      2'b10:   inflight_d = inflight_q + CNT_ONE;
      2'b01:   inflight_d = inflight_q - CNT_ONE;
      default: inflight_d = inflight_q;
    endcase
    // drop_q never exceeds inflight_q, so on a redirect every request still
    // outstanding after this cycle's response becomes a discard.
    if (REDIR) begin
      drop_d = resp_s ? (inflight_q - CNT_ONE) : inflight_q;
    end else if (drop_hit_s) begin
      drop_d = drop_q - CNT_ONE;
    end else begin
      drop_d = drop_q;
    end
  end

  // State registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fpc_q      <= ifq_word_align(RESET_PC);
      inflight_q <= CNT_ZERO;
      drop_q     <= CNT_ZERO;
    end else begin
      fpc_q      <= fpc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue. A memory model answers grants after a
// programmable latency and only grants up to a budget set by the stimulus.
// Expected PCs are queued as stimulus is issued; a monitor pops and compares
// on every decode handshake.
module tb_ifetch_queue;
  import ifetch_queue_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        IM_REQ;
  logic [29:0] IM_ADDR;
  logic        IM_GNT;
  logic        IM_RVALID;
  logic [31:0] IM_RDATA;
  logic        IF_VALID;
  logic [31:0] IF_PC;
  logic [31:0] IF_IR;
  logic        IF_READY;
  logic        REDIR;
  logic [31:0] REDIR_PC;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q [$];
  int          due_q [$];
  logic [29:0] addr_q [$];
  int          lat;
  int          gnt_limit;
  int          grants_total;
  int          cyc;
  logic        g_s = 1'b0;
  logic [29:0] a_s = 30'h0;
  int          hs [4];
  int          n_hs;
  int          n_g;

`ifdef IFQ_BYPASS_EN
  localparam int EXP_FIRST = 1;
`else
  localparam int EXP_FIRST = 2;
`endif

  ifetch_queue #(
    .DEPTH   (IFQ_DEPTH),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .IM_REQ   (IM_REQ),
    .IM_ADDR  (IM_ADDR),
    .IM_GNT   (IM_GNT),
    .IM_RVALID(IM_RVALID),
    .IM_RDATA (IM_RDATA),
    .IF_VALID (IF_VALID),
    .IF_PC    (IF_PC),
    .IF_IR    (IF_IR),
    .IF_READY (IF_READY),
    .REDIR    (REDIR),
    .REDIR_PC (REDIR_PC)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [29:0] wa);
    return {wa, 2'b00} ^ 32'h5A00_0013;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive_tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    check32({name, "_drain_left"}, exp_q.size(), 32'd0);
  endtask

  // Memory model: latches grants at negedge, answers lat cycles after grant.
  initial begin
    IM_GNT = 1'b0; IM_RVALID = 1'b0; IM_RDATA = 32'h0;
    cyc = 0; grants_total = 0;
    forever begin
      @(posedge CLK);
      #2;
      cyc++;
      if (g_s) begin
        grants_total++;
        due_q.push_back(cyc - 1 + lat);
        addr_q.push_back(a_s);
      end
      IM_RVALID = 1'b0;
      IM_RDATA  = 32'h0;
      if (due_q.size() != 0 && due_q[0] == cyc) begin
        IM_RVALID = 1'b1;
        IM_RDATA  = mem_word(addr_q[0]);
        void'(due_q.pop_front());
        void'(addr_q.pop_front());
      end
      IM_GNT = (grants_total < gnt_limit);
    end
  end

  // Monitor: sample request channel and score every decode handshake.
  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(negedge CLK);
      g_s = IM_REQ && IM_GNT;
      a_s = IM_ADDR;
      if (!RST && IF_VALID && IF_READY) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_handshake: got pc %h, expected none", IF_PC);
        end else begin
          e = exp_q.pop_front();
          check32("if_pc", IF_PC, e);
          check32("if_ir", IF_IR, mem_word(e[31:2]));
        end
      end
    end
  end

  initial begin
    RST = 1'b1; IF_READY = 1'b0; REDIR = 1'b0; REDIR_PC = 32'h0;
    gnt_limit = 0; lat = 1;
    for (int i = 0; i < 4; i++) hs[i] = -100;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check32("rst_im_req", {31'h0, IM_REQ}, 32'd0);
    check32("rst_im_addr", {2'b00, IM_ADDR}, 32'h0);
    check32("rst_if_valid", {31'h0, IF_VALID}, 32'd0);
    check32("rst_if_pc", IF_PC, 32'h0);
    check32("rst_if_ir", IF_IR, 32'h0);

    // 1: reset release, latency 1, decode always ready
    drive_tick();
    RST = 1'b0; IF_READY = 1'b1; gnt_limit = grants_total + 4;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    exp_q.push_back(32'h8); exp_q.push_back(32'hC);
    n_hs = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge CLK);
      if (k == 0) begin
        check32("first_im_req", {31'h0, IM_REQ}, 32'd1);
        check32("first_im_addr", {2'b00, IM_ADDR}, 32'h0);
      end
      if (IF_VALID && IF_READY && n_hs < 4) begin
        hs[n_hs] = k;
        n_hs++;
      end
    end
    check32("stream_count", n_hs, 32'd4);
    check32("first_latency", hs[0], EXP_FIRST);
    for (int i = 1; i < 4; i++) check32("back_to_back", hs[i] - hs[i-1], 32'd1);
    wait_drain("stream");

    // 2: decode stalled -> exactly DEPTH grants, then in-order release
    drive_tick();
    REDIR = 1'b1; REDIR_PC = 32'h0; IF_READY = 1'b0; gnt_limit = 1000;
    drive_tick();
    REDIR = 1'b0;
    n_g = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      if (IM_REQ && IM_GNT) n_g++;
    end
    check32("stall_grants", n_g, 32'd4);
    check32("stall_im_req", {31'h0, IM_REQ}, 32'd0);
    check32("stall_if_valid", {31'h0, IF_VALID}, 32'd1);
    check32("stall_if_pc", IF_PC, 32'h0);
    drive_tick();
    gnt_limit = grants_total; IF_READY = 1'b1;
    exp_q.push_back(32'h0); exp_q.push_back(32'h4);
    exp_q.push_back(32'h8); exp_q.push_back(32'hC);
    wait_drain("stall_release");

    // 3: three requests in flight (latency 3) then redirect to 0x102
    drive_tick();
    lat = 3; gnt_limit = grants_total + 3;
    repeat (3) drive_tick();
    REDIR = 1'b1; REDIR_PC = 32'h0000_0102; gnt_limit = gnt_limit + 1;
    exp_q.push_back(32'h0000_0100);
    drive_tick();
    REDIR = 1'b0;
    @(negedge CLK);
    check32("redir_im_req", {31'h0, IM_REQ}, 32'd1);
    check32("redir_im_addr", {2'b00, IM_ADDR}, 32'h40);
    check32("redir_if_valid", {31'h0, IF_VALID}, 32'd0);
    wait_drain("redir_inflight");

    // 4: redirect together with a response and a decode pop
    drive_tick();
    IF_READY = 1'b0; lat = 3; gnt_limit = grants_total + 3;
    repeat (4) drive_tick();
    REDIR = 1'b1; REDIR_PC = 32'h0000_0200; IF_READY = 1'b1;
    gnt_limit = gnt_limit + 1;
    exp_q.push_back(32'h0000_0104); exp_q.push_back(32'h0000_0200);
    drive_tick();
    REDIR = 1'b0;
    @(negedge CLK);
    check32("redir_pop_if_valid", {31'h0, IF_VALID}, 32'd0);
    check32("redir_pop_im_addr", {2'b00, IM_ADDR}, 32'h80);
    wait_drain("redir_pop");

    // 5: fetch address wrap at the top of memory
    drive_tick();
    REDIR = 1'b1; REDIR_PC = 32'hFFFF_FFFC; lat = 1; gnt_limit = grants_total + 2;
    exp_q.push_back(32'hFFFF_FFFC); exp_q.push_back(32'h0);
    drive_tick();
    REDIR = 1'b0;
    @(negedge CLK);
    check32("wrap_addr_top", {2'b00, IM_ADDR}, 32'h3FFF_FFFF);
    @(negedge CLK);
    check32("wrap_addr_zero", {2'b00, IM_ADDR}, 32'h0);
    wait_drain("wrap");

    // 6: reset asserted with a non-empty queue clears everything at once
    drive_tick();
    IF_READY = 1'b0; gnt_limit = grants_total + 2;
    repeat (5) drive_tick();
    check32("pre_reset_if_valid", {31'h0, IF_VALID}, 32'd1);
    RST = 1'b1;
    #1;
    check32("mid_reset_if_valid", {31'h0, IF_VALID}, 32'd0);
    check32("mid_reset_im_req", {31'h0, IM_REQ}, 32'd0);
    check32("mid_reset_if_pc", IF_PC, 32'h0);
    check32("mid_reset_im_addr", {2'b00, IM_ADDR}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
